// File: rtl/artemis_clk_rst_seq_if.sv
// Sequencer boundary: PLL lock and software restart in; PLL reset, channel resets and status out.
interface artemis_clk_rst_seq_if #(
    parameter int NUM_CHAN = 4
);
    logic                pll_locked;
    logic                sw_reset;
    logic                pll_rst;
    logic [NUM_CHAN-1:0] chan_rst;
    logic                ready;
    logic                fail;
    logic [7:0]          lock_loss_count;

    modport master (
        input  pll_locked, sw_reset,
        output pll_rst, chan_rst, ready, fail, lock_loss_count
    );

    modport slave (
        output pll_locked, sw_reset,
        input  pll_rst, chan_rst, ready, fail, lock_loss_count
    );
endinterface

// File: rtl/artemis_clk_rst_seq.sv
// Power-up sequencer: pulses the PLL reset, qualifies lock, retries on timeout and
// releases downstream channel resets one by one; any lock loss restarts the sequence.
module artemis_clk_rst_seq #(
    parameter int NUM_CHAN           = 4,
    parameter int SYNC_STAGES        = 2,
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_STABLE_CYCLES = 256,
    parameter int LOCK_TIMEOUT       = 65536,
    parameter int CHAN_STAGGER       = 8,
    parameter int MAX_RETRY          = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    artemis_clk_rst_seq_if.master bus
);
    localparam int REL_SPAN = NUM_CHAN * CHAN_STAGGER;
    localparam int MAX_A    = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CNT  = (MAX_A > REL_SPAN) ? MAX_A : REL_SPAN;
    localparam int CNT_W    = $clog2(MAX_CNT + 1);
    localparam int RTY_W    = $clog2(MAX_RETRY + 2);

    localparam logic [CNT_W-1:0] PLL_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_GOAL = CNT_W'(LOCK_STABLE_CYCLES);
    localparam logic [RTY_W-1:0] RETRY_LIMIT = RTY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        RELEASE,
        RUN,
        FAIL
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] lock_sync;
    logic                   lock_s;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       stable;
    logic [CNT_W-1:0]       cnt_inc;
    logic [CNT_W-1:0]       stable_inc;
    logic [RTY_W-1:0]       retry;
    logic                   pll_rst_q;
    logic [NUM_CHAN-1:0]    chan_rst_q;
    logic                   ready_q;
    logic                   fail_q;
    logic [7:0]             loss_q;

    assign lock_s     = lock_sync[SYNC_STAGES-1];
    assign cnt_inc    = cnt + CNT_W'(1);
    assign stable_inc = stable + CNT_W'(1);

    // Stage boundary: asynchronous pll_locked enters the clk domain here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_sync <= '0;
        end else begin
            lock_sync <= {lock_sync[SYNC_STAGES-2:0], bus.pll_locked};
        end
    end

    // Stage boundary: sequencer state and every output are registered together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= PLL_RST;
            cnt        <= '0;
            stable     <= '0;
            retry      <= '0;
            pll_rst_q  <= 1'b1;
            chan_rst_q <= '1;
            ready_q    <= 1'b0;
            fail_q     <= 1'b0;
            loss_q     <= '0;
        end else if (bus.sw_reset) begin
            state      <= PLL_RST;
            cnt        <= '0;
            retry      <= '0;
            pll_rst_q  <= 1'b1;
            chan_rst_q <= '1;
            ready_q    <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            case (state)
                PLL_RST: begin
                    if (cnt == PLL_LAST) begin
                        state     <= WAIT_LOCK;
                        cnt       <= '0;
                        stable    <= '0;
                        pll_rst_q <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                WAIT_LOCK: begin
                    stable <= lock_s ? stable_inc : '0;
                    if (lock_s && (stable_inc == STABLE_GOAL)) begin
                        state <= RELEASE;
                        cnt   <= '0;
                        retry <= '0;
                    end else if (cnt == WAIT_LAST) begin
                        cnt <= '0;
                        if (retry < RETRY_LIMIT) begin
                            retry     <= retry + RTY_W'(1);
                            state     <= PLL_RST;
                            pll_rst_q <= 1'b1;
                        end else begin
                            state  <= FAIL;
                            fail_q <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                RELEASE, RUN: begin
                    if (!lock_s) begin
                        state      <= PLL_RST;
                        cnt        <= '0;
                        pll_rst_q  <= 1'b1;
                        chan_rst_q <= '1;
                        ready_q    <= 1'b0;
                        if (loss_q != 8'hFF) loss_q <= loss_q + 8'd1;
                    end else if (state == RELEASE) begin
                        // RUN waits one cycle past the last channel's release.
                        if (!chan_rst_q[NUM_CHAN-1]) begin
                            state   <= RUN;
                            ready_q <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                            for (int i = 0; i < NUM_CHAN; i++) begin
                                if (cnt_inc >= CNT_W'((i + 1) * CHAN_STAGGER)) chan_rst_q[i] <= 1'b0;
                            end
                        end
                    end
                end
                FAIL: begin
                    fail_q <= 1'b1;
                end
                default: begin
                    state      <= PLL_RST;
                    cnt        <= '0;
                    pll_rst_q  <= 1'b1;
                    chan_rst_q <= '1;
                    ready_q    <= 1'b0;
                    fail_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pll_rst         = pll_rst_q;
    assign bus.chan_rst        = chan_rst_q;
    assign bus.ready           = ready_q;
    assign bus.fail            = fail_q;
    assign bus.lock_loss_count = loss_q;
endmodule

// File: doc/artemis_clk_rst_seq.md
ARTEMIS_CLK_RST_SEQ -- requirements
Module: artemis_clk_rst_seq

Interface
REQ-001 SHALL have parameter NUM_CHAN, default 4: number of downstream reset channels (1..16).
REQ-002 SHALL have parameter SYNC_STAGES, default 2: flop depth of the pll_locked synchroniser (>=2).
REQ-003 SHALL have parameter PLL_RST_CYCLES, default 16: pll_rst pulse length in clk cycles (>=1).
REQ-004 SHALL have parameter LOCK_STABLE_CYCLES, default 256: consecutive synced-lock-high cycles required to accept lock (>=1).
REQ-005 SHALL have parameter LOCK_TIMEOUT, default 65536: maximum WAIT_LOCK cycles per attempt (>LOCK_STABLE_CYCLES).
REQ-006 SHALL have parameter CHAN_STAGGER, default 8: cycles between successive channel reset releases (>=1).
REQ-007 SHALL have parameter MAX_RETRY, default 3: PLL reset retries before declaring failure (>=0).
REQ-008 clk  input  1  system clock; all logic on rising edge.
REQ-009 rst  input  1  asynchronous, active-high reset.
REQ-010 pll_locked  input  1  PLL LOCKED, asynchronous to clk.
REQ-011 sw_reset  input  1  synchronous single-cycle request to restart the full sequence.
REQ-012 pll_rst  output  1  reset to the PLL, active-high.
REQ-013 chan_rst  output  NUM_CHAN  per-channel synchronous reset, active-high.
REQ-014 ready  output  1  high when all channels released and lock held.
REQ-015 fail  output  1  high when retries exhausted.
REQ-016 lock_loss_count  output  8  saturating count of lock losses in RUN/RELEASE.

Function
REQ-017 pll_locked SHALL pass through SYNC_STAGES flops before use; "lock_s" denotes the synchronised value.
REQ-018 FSM states SHALL be PLL_RST, WAIT_LOCK, RELEASE, RUN, FAIL.
REQ-019 PLL_RST: pll_rst=1 for exactly PLL_RST_CYCLES cycles, then WAIT_LOCK.
REQ-020 WAIT_LOCK: stable counter increments while lock_s=1, clears when lock_s=0; reaching LOCK_STABLE_CYCLES SHALL enter RELEASE and clear the retry counter.
REQ-021 WAIT_LOCK: after LOCK_TIMEOUT cycles without acceptance, if retry count < MAX_RETRY SHALL increment it and enter PLL_RST, else enter FAIL.
REQ-022 RELEASE: chan_rst[i] SHALL deassert (i+1)*CHAN_STAGGER cycles after RELEASE entry, index 0 first; once deasserted a channel stays low while in RELEASE/RUN.
REQ-023 The cycle after chan_rst[NUM_CHAN-1] deasserts SHALL enter RUN; ready=1 exactly while in RUN.
REQ-024 lock_s=0 in RELEASE or RUN SHALL, next cycle, assert all chan_rst, clear ready, increment lock_loss_count (saturate at 255) and enter PLL_RST.
REQ-025 FAIL: fail=1, pll_rst=0, all chan_rst=1; leaves only via sw_reset or rst.
REQ-026 sw_reset=1 in any state SHALL next cycle enter PLL_RST with all chan_rst=1, retry counter cleared, lock_loss_count unchanged; sw_reset has priority over lock loss and timeout in the same cycle.
REQ-027 sw_reset asserted during PLL_RST SHALL restart the PLL_RST_CYCLES count.
REQ-028 chan_rst SHALL be all ones in every state other than RELEASE/RUN.
REQ-029 All outputs SHALL be registered; no combinational path from pll_locked or sw_reset to an output.

Reset
REQ-030 rst=1 SHALL asynchronously force state PLL_RST, pll_rst=1, chan_rst all ones, ready=0, fail=0, lock_loss_count=0, all counters and synchroniser flops 0.
REQ-031 After rst deasserts, the PLL_RST count SHALL begin on the first rising clk edge, giving PLL_RST_CYCLES total cycles of pll_rst.
REQ-032 rst asserted mid-sequence SHALL take effect immediately regardless of state.

Verification (NUM_CHAN=3, SYNC_STAGES=2, PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT=64, CHAN_STAGGER=2, MAX_RETRY=2)
REQ-033 Nominal: release rst, pll_locked=1 from cycle 6 -> pll_rst high 4 cycles; chan_rst 111->110->100->000 at 2-cycle spacing; ready=1 one cycle after 000.
REQ-034 Glitchy lock: pll_locked toggles every 5 cycles in WAIT_LOCK, then steady -> no RELEASE until 8 consecutive lock_s highs.
REQ-035 No lock: pll_locked=0 -> three pll_rst pulses of 4 cycles each (initial + 2 retries), then fail=1, chan_rst=111; sw_reset clears fail and restarts.
REQ-036 Lock loss in RUN: drop pll_locked -> chan_rst=111, ready=0 within SYNC_STAGES+1 cycles, lock_loss_count 0->1, full sequence repeats; 300 losses -> count holds 255.
REQ-037 Simultaneous: sw_reset and lock loss same cycle in RUN -> PLL_RST entered, lock_loss_count unchanged.
REQ-038 Async rst asserted mid-RELEASE with clk stopped -> outputs reach reset values without a clock edge.
